// File: rtl/match_timer.sv
`default_nettype none
// ============================================================================
// match_timer : pausable up/down BCD game clock with active-low 7-seg outputs
// Rev 1.0
// ============================================================================
module match_timer #(
  parameter int TICK_CYCLES = 50000000,
  parameter int DIGITS      = 2,
  parameter int LIMIT       = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  down,
  output logic [4*DIGITS-1:0]   value_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  running,
  output logic                  expired
);

  localparam int c_pw = $clog2(TICK_CYCLES);
  localparam logic [c_pw-1:0] c_tick_last = c_pw'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam logic [4*DIGITS-1:0] c_limit_bcd = to_bcd(LIMIT);

  // Ripple a +/-1 through the digits; a digit only changes while carry/borrow is live.
  function automatic logic [4*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                   input logic dn);
    logic [4*DIGITS-1:0] r;
    logic                cy;
    logic [3:0]          d;
    r  = v;
    cy = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (cy) begin
        if (!dn) begin
          if (d >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0011000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [c_pw-1:0]     presc_q, presc_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic                dir_q, dir_d;
  logic                running_q, running_d;
  logic                expired_q, expired_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  logic                tick;
  logic                hit_terminal;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] terminal;

  assign tick         = (presc_q == c_tick_last);
  assign stepped      = bcd_step(val_q, dir_q);
  assign terminal     = dir_q ? '0 : c_limit_bcd;
  assign hit_terminal = tick && (stepped == terminal);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    val_d     = val_q;
    dir_d     = dir_q;
    expired_d = 1'b0;

    if (start) begin
      state_d = RUN;
      presc_d = '0;
      dir_d   = down;
      val_d   = down ? c_limit_bcd : '0;
    end else begin
      case (state_q)
        RUN: begin
          // The RUN cycle that samples pause still counts, so RUN time per tick stays fixed.
          presc_d = tick ? '0 : presc_q + c_pw'(1);
          if (tick) begin
            val_d = stepped;
          end
          if (hit_terminal) begin
            state_d   = DONE;
            expired_d = 1'b1;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
        end
      endcase
    end

    running_d = (state_d == RUN);

    seg_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg_d[7*i +: 7] = (state_q == IDLE) ? 7'b1111111 : seg_enc(val_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      val_q     <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      seg_q     <= '1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      val_q     <= val_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      expired_q <= expired_d;
      seg_q     <= seg_d;
    end
  end

  assign value_bcd = val_q;
  assign seg       = seg_q;
  assign running   = running_q;
  assign expired   = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_match_timer.sv
`default_nettype none
// ============================================================================
// tb_match_timer : directed scoreboard bench for match_timer (TICK=4, 2 digits, LIMIT=12)
// Rev 1.0
// ============================================================================
module tb_match_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        down = 1'b0;
  logic [7:0]  value_bcd;
  logic [13:0] seg;
  logic        running;
  logic        expired;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
    logic       expd;
    logic       run;
    int         gap;
  } sb_item_t;

  sb_item_t   sb_q[$];
  logic [7:0] exp_val;

  match_timer #(
    .TICK_CYCLES(4),
    .DIGITS     (2),
    .LIMIT      (12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .down     (down),
    .value_bcd(value_bcd),
    .seg      (seg),
    .running  (running),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0011000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] seg_of(input logic [7:0] v);
    return {enc(v[7:4]), enc(v[3:0])};
  endfunction

  function automatic logic [7:0] bcd8(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] v, input logic e,
                      input logic r, input int g);
    sb_item_t it;
    it.tag  = tag;
    it.val  = v;
    it.expd = e;
    it.run  = r;
    it.gap  = g;
    sb_q.push_back(it);
  endtask

  task automatic do_start(input logic dn, input logic [7:0] ld);
    start = 1'b1;
    down  = dn;
    pause = 1'b0;
    step();
    start = 1'b0;
    exp_val = ld;
    chk("start.value", 32'(value_bcd), 32'(ld));
    chk("start.running", 32'(running), 1);
  endtask

  // Pops one expected item each time the displayed value moves; bounded by budget cycles.
  task automatic run_sb(input int budget);
    sb_item_t   it;
    int         gap;
    int         cyc;
    logic [7:0] seen;
    gap  = 0;
    cyc  = 0;
    seen = value_bcd;
    while (sb_q.size() > 0 && cyc < budget) begin
      step();
      cyc++;
      gap++;
      chk("sb.seg", 32'(seg), 32'(seg_of(exp_val)));
      if (value_bcd !== seen) begin
        it = sb_q.pop_front();
        chk({it.tag, ".val"}, 32'(value_bcd), 32'(it.val));
        chk({it.tag, ".gap"}, 32'(gap), 32'(it.gap));
        chk({it.tag, ".expired"}, 32'(expired), 32'(it.expd));
        chk({it.tag, ".running"}, 32'(running), 32'(it.run));
        exp_val = it.val;
        seen    = value_bcd;
        gap     = 0;
      end else begin
        chk("sb.quiet_expired", 32'(expired), 0);
        chk("sb.quiet_running", 32'(running), 1);
      end
    end
    if (sb_q.size() > 0) begin
      chk("sb.timeout_pending", 32'(sb_q.size()), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    // 1: reset defaults
    repeat (3) step();
    chk("rst.value", 32'(value_bcd), 0);
    chk("rst.seg", 32'(seg), 32'h3FFF);
    chk("rst.running", 32'(running), 0);
    chk("rst.expired", 32'(expired), 0);
    reset = 1'b1;
    repeat (6) step();
    chk("idle.value", 32'(value_bcd), 0);
    chk("idle.seg", 32'(seg), 32'h3FFF);
    chk("idle.running", 32'(running), 0);

    // 2: count up through the BCD carry to expiry
    do_start(1'b0, 8'h00);
    for (int v = 1; v <= 12; v++) begin
      push("up", bcd8(v), v == 12, v != 12, 4);
    end
    run_sb(80);
    step();
    chk("up.done_value", 32'(value_bcd), 32'h12);
    chk("up.done_expired", 32'(expired), 0);
    chk("up.done_running", 32'(running), 0);
    chk("up.done_seg", 32'(seg), 32'({7'b1111001, 7'b0100100}));

    // 3: count down through the borrow to zero, then hold
    do_start(1'b1, 8'h12);
    for (int v = 11; v >= 0; v--) begin
      push("dn", bcd8(v), v == 0, v != 0, 4);
    end
    run_sb(80);
    repeat (5) step();
    chk("dn.hold_value", 32'(value_bcd), 0);
    chk("dn.hold_expired", 32'(expired), 0);
    chk("dn.hold_running", 32'(running), 0);

    // 4: pause two cycles after a tick retains the prescaler
    do_start(1'b0, 8'h00);
    push("p", 8'h01, 1'b0, 1'b1, 4);
    run_sb(20);
    step();
    step();
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("pause.value", 32'(value_bcd), 32'h01);
      if (i == 3) chk("pause.running", 32'(running), 0);
    end
    pause = 1'b0;
    step();
    chk("resume1.value", 32'(value_bcd), 32'h01);
    step();
    chk("resume2.value", 32'(value_bcd), 32'h02);
    chk("resume2.running", 32'(running), 1);
    chk("resume2.expired", 32'(expired), 0);

    // 5a: start on the terminal-tick cycle wins over expiry
    exp_val = 8'h02;
    for (int v = 3; v <= 11; v++) begin
      push("pre", bcd8(v), 1'b0, 1'b1, 4);
    end
    run_sb(60);
    repeat (3) step();
    start = 1'b1;
    down  = 1'b0;
    step();
    start = 1'b0;
    chk("prio.value", 32'(value_bcd), 0);
    chk("prio.running", 32'(running), 1);
    chk("prio.expired", 32'(expired), 0);
    step();
    chk("prio.next_expired", 32'(expired), 0);
    chk("prio.next_value", 32'(value_bcd), 0);

    // 5b: start together with pause reloads, then pauses
    start = 1'b1;
    pause = 1'b1;
    down  = 1'b1;
    step();
    start = 1'b0;
    chk("sp.value", 32'(value_bcd), 32'h12);
    chk("sp.running", 32'(running), 1);
    step();
    chk("sp.paused_running", 32'(running), 0);
    repeat (5) step();
    chk("sp.held_value", 32'(value_bcd), 32'h12);
    chk("sp.held_running", 32'(running), 0);
    pause = 1'b0;

    // 6: asynchronous reset mid-run at 07
    do_start(1'b0, 8'h00);
    for (int v = 1; v <= 7; v++) begin
      push("ar", bcd8(v), 1'b0, 1'b1, 4);
    end
    run_sb(40);
    #3;
    reset = 1'b0;
    #1;
    chk("arst.value", 32'(value_bcd), 0);
    chk("arst.seg", 32'(seg), 32'h3FFF);
    chk("arst.running", 32'(running), 0);
    chk("arst.expired", 32'(expired), 0);
    step();
    step();
    reset = 1'b1;
    repeat (8) step();
    chk("post.value", 32'(value_bcd), 0);
    chk("post.seg", 32'(seg), 32'h3FFF);
    chk("post.running", 32'(running), 0);
    chk("post.expired", 32'(expired), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
